mem_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch and the load/store stage. It arbitrates between the two requesters and latches the winning request for the duration of the transaction. It routes the memory response back to the requester that owns the transaction. Data accesses have priority, with a starvation guard that limits how long fetch can wait. The block sits between the pipeline's fetch/memory stages and the memory bus, and is invisible to the decoder and ALU.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between instruction fetch and
// the load/store stage. Data has priority; a streak counter bounds how many
// data grants may pass a waiting fetch. The winning request is latched for
// the whole transaction and the response is steered back to its owner.
module mem_arbiter #(
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        ireq_valid,
   input  logic [63:0] ireq_addr,
   output logic        iresp_data_ok,
   output logic [31:0] iresp_data,

   input  logic        dreq_valid,
   input  logic [63:0] dreq_addr,
   input  logic        dreq_write,
   input  logic [7:0]  dreq_strobe,
   input  logic [63:0] dreq_data,
   output logic        dresp_data_ok,
   output logic [63:0] dresp_data,

   output logic        mreq_valid,
   output logic [63:0] mreq_addr,
   output logic        mreq_write,
   output logic [7:0]  mreq_strobe,
   output logic [63:0] mreq_data,
   input  logic        mresp_data_ok,
   input  logic [63:0] mresp_data
);

   localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } state_t;

   state_t        state_q;
   logic [SW-1:0] streak_q;
   logic [SW-1:0] streak_d;

   logic          mreq_valid_q;
   logic [63:0]   mreq_addr_q;
   logic          mreq_write_q;
   logic [7:0]    mreq_strobe_q;
   logic [63:0]   mreq_data_q;

   logic          gnt_data;
   logic          gnt_fetch;

   // Arbitration decision and streak update, used only while IDLE
   always_comb begin
      gnt_data  = 1'b0;
      gnt_fetch = 1'b0;
      streak_d  = streak_q;
      if (dreq_valid && !(ireq_valid && (streak_q == STREAK_MAX))) begin
         gnt_data = 1'b1;
         if (ireq_valid) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
         end else begin
            streak_d = '0;
         end
      end else if (ireq_valid) begin
         gnt_fetch = 1'b1;
         streak_d  = '0;
      end
   end

   // Transaction FSM: grant in IDLE, hold latched request until completion
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         streak_q      <= '0;
         mreq_valid_q  <= 1'b0;
         mreq_addr_q   <= '0;
         mreq_write_q  <= 1'b0;
         mreq_strobe_q <= '0;
         mreq_data_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_data) begin
                  state_q       <= DBUSY;
                  streak_q      <= streak_d;
                  mreq_valid_q  <= 1'b1;
                  mreq_addr_q   <= dreq_addr;
                  mreq_write_q  <= dreq_write;
                  mreq_strobe_q <= dreq_strobe;
                  mreq_data_q   <= dreq_data;
               end else if (gnt_fetch) begin
                  state_q       <= IBUSY;
                  streak_q      <= streak_d;
                  mreq_valid_q  <= 1'b1;
                  mreq_addr_q   <= ireq_addr;
                  mreq_write_q  <= 1'b0;
                  mreq_strobe_q <= '0;
                  mreq_data_q   <= '0;
               end
            end
            IBUSY, DBUSY: begin
               if (mresp_data_ok) begin
                  state_q      <= IDLE;
                  mreq_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               mreq_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign mreq_valid  = mreq_valid_q;
   assign mreq_addr   = mreq_addr_q;
   assign mreq_write  = mreq_write_q;
   assign mreq_strobe = mreq_strobe_q;
   assign mreq_data   = mreq_data_q;

   // Responses are steered combinationally to the owner of the transaction
   assign iresp_data_ok = mresp_data_ok & (state_q == IBUSY);
   assign dresp_data_ok = mresp_data_ok & (state_q == DBUSY);
   assign iresp_data    = mreq_addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
   assign dresp_data    = mresp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written grant-order and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

   localparam int unsigned MAXS = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic        dreq_write;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        mreq_valid;
   logic [63:0] mreq_addr;
   logic        mreq_write;
   logic [7:0]  mreq_strobe;
   logic [63:0] mreq_data;
   logic        mresp_data_ok;
   logic [63:0] mresp_data;

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_DSTREAK(MAXS)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_write(mreq_write),
      .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
      .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [63:0] ia, input logic dv,
                        input logic [63:0] da, input logic dw, input logic [7:0] ds,
                        input logic [63:0] dd, input logic mok, input logic [63:0] md);
      ireq_valid = iv;  ireq_addr = ia;
      dreq_valid = dv;  dreq_addr = da; dreq_write = dw; dreq_strobe = ds; dreq_data = dd;
      mresp_data_ok = mok; mresp_data = md;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        iv;  logic [63:0] ia;
      logic        dv;  logic [63:0] da; logic dw; logic [7:0] ds; logic [63:0] dd;
      logic        mok; logic [63:0] md;
      logic        ev;  logic [63:0] ea; logic ew; logic [7:0] es; logic [63:0] edt;
      logic        eiok; logic [31:0] eid; logic edok;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      logic iv, logic [63:0] ia, logic dv, logic [63:0] da, logic dw, logic [7:0] ds,
      logic [63:0] dd, logic mok, logic [63:0] md,
      logic ev, logic [63:0] ea, logic ew, logic [7:0] es, logic [63:0] edt,
      logic eiok, logic [31:0] eid, logic edok);
      vec_t v;
      v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw; v.ds = ds; v.dd = dd;
      v.mok = mok; v.md = md; v.ev = ev; v.ea = ea; v.ew = ew; v.es = es; v.edt = edt;
      v.eiok = eiok; v.eid = eid; v.edok = edok;
      return v;
   endfunction

   // ---------------- reference model ----------------
   int          m_owner;   // 0 none, 1 fetch, 2 data
   logic [63:0] m_addr;
   logic        m_write;
   logic [7:0]  m_strobe;
   logic [63:0] m_data;
   int          m_dwins;   // data grants passed over a waiting fetch

   task automatic model_reset();
      m_owner = 0; m_addr = '0; m_write = 1'b0; m_strobe = '0; m_data = '0; m_dwins = 0;
   endtask

   task automatic model_step();
      logic fetch_due;
      if (reset) begin
         model_reset();
      end else if (m_owner == 0) begin
         fetch_due = ireq_valid && (m_dwins >= MAXS);
         if (dreq_valid && !fetch_due) begin
            m_owner = 2; m_addr = dreq_addr; m_write = dreq_write;
            m_strobe = dreq_strobe; m_data = dreq_data;
            m_dwins = ireq_valid ? ((m_dwins + 1 > MAXS) ? MAXS : m_dwins + 1) : 0;
         end else if (ireq_valid) begin
            m_owner = 1; m_addr = ireq_addr; m_write = 1'b0; m_strobe = '0; m_data = '0;
            m_dwins = 0;
         end
      end else if (mresp_data_ok) begin
         m_owner = 0;
      end
   endtask

   task automatic model_check();
      logic ei, ed;
      ei = mresp_data_ok && (m_owner == 1);
      ed = mresp_data_ok && (m_owner == 2);
      chk("rnd mreq_valid", mreq_valid, (m_owner != 0));
      if (m_owner != 0) begin
         chk("rnd mreq_addr", mreq_addr, m_addr);
         chk("rnd mreq_write", mreq_write, m_write);
         chk("rnd mreq_strobe", mreq_strobe, m_strobe);
         chk("rnd mreq_data", mreq_data, m_data);
      end
      chk("rnd iresp_ok", iresp_data_ok, ei);
      chk("rnd dresp_ok", dresp_data_ok, ed);
      if (ei) chk("rnd iresp_data", iresp_data, m_addr[2] ? mresp_data[63:32] : mresp_data[31:0]);
      if (ed) chk("rnd dresp_data", dresp_data, mresp_data);
   endtask

   // Hold both requesters, answer every request one cycle after issue, log grant order
   task automatic run_grants(input int n, output string s);
      logic prev;
      int   got;
      s = "";
      got = 0;
      prev = mreq_valid;
      for (int c = 0; c < 200 && got < n; c++) begin
         mresp_data_ok = mreq_valid;
         @(negedge clk);
         if (mreq_valid && !prev) begin
            if (mreq_addr == 64'h2000) s = {s, "D"};
            else s = {s, "I"};
            got++;
         end
         prev = mreq_valid;
         @(posedge clk); #1;
      end
      mresp_data_ok = 1'b0;
   endtask

   initial begin
      string g;
      vec_t  v;

      // reset state
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset mreq_valid", mreq_valid, 0);
      chk("reset mreq_addr", mreq_addr, 0);
      chk("reset mreq_write", mreq_write, 0);
      chk("reset mreq_strobe", mreq_strobe, 0);
      chk("reset mreq_data", mreq_data, 0);
      chk("reset iresp_ok", iresp_data_ok, 0);
      chk("reset dresp_ok", dresp_data_ok, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // fetch upper word
      tbl.push_back(mk(1,64'h80000004,0,0,0,0,0,0,0,                    0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000004,0,0,0,0,0,0,0,                    1,64'h80000004,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000004,0,0,0,0,0,0,0,                    1,64'h80000004,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000004,0,0,0,0,0,0,0,                    1,64'h80000004,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000004,0,0,0,0,0,1,64'h1122334455667788, 1,64'h80000004,0,0,0,1,32'h11223344,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                               0,0,0,0,0,0,0,0));
      // both requesters: load first, fetch two cycles after load completes
      tbl.push_back(mk(1,64'h80000000,1,64'h80001000,0,0,0,0,0,         0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000000,1,64'h80001000,0,0,0,0,0,         1,64'h80001000,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000000,1,64'h80001000,0,0,0,1,64'h0123456789ABCDEF, 1,64'h80001000,0,0,0,0,0,1));
      tbl.push_back(mk(1,64'h80000000,0,0,0,0,0,0,0,                    0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000000,0,0,0,0,0,0,0,                    1,64'h80000000,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h80000000,0,0,0,0,0,1,64'hAAAABBBBCCCCDDDD, 1,64'h80000000,0,0,0,1,32'hCCCCDDDD,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                               0,0,0,0,0,0,0,0));
      // store latching: fields change after the grant
      tbl.push_back(mk(0,0,1,64'h80002008,1,8'h0F,64'hDEADBEEF,0,0,     0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,1,8'h0F,64'hDEADBEEF,0,0,                1,64'h80002008,1,8'h0F,64'hDEADBEEF,0,0,0));
      tbl.push_back(mk(0,0,1,0,1,8'h0F,0,0,0,                           1,64'h80002008,1,8'h0F,64'hDEADBEEF,0,0,0));
      tbl.push_back(mk(0,0,1,0,1,8'h0F,0,1,64'h42,                      1,64'h80002008,1,8'h0F,64'hDEADBEEF,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                               0,0,0,0,0,0,0,0));
      // spurious completion in IDLE, then a fetch is still granted normally
      tbl.push_back(mk(0,0,0,0,0,0,0,1,64'hFFFFFFFFFFFFFFFF,            0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h4,0,0,0,0,0,0,0,                           0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h4,0,0,0,0,0,0,0,                           1,64'h4,0,0,0,0,0,0));
      tbl.push_back(mk(1,64'h4,0,0,0,0,0,1,64'h5555666677778888,        1,64'h4,0,0,0,1,32'h55556666,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                               0,0,0,0,0,0,0,0));

      foreach (tbl[i]) begin
         v = tbl[i];
         drive(v.iv, v.ia, v.dv, v.da, v.dw, v.ds, v.dd, v.mok, v.md);
         @(negedge clk);
         chk($sformatf("vec%0d mreq_valid", i), mreq_valid, v.ev);
         if (v.ev) begin
            chk($sformatf("vec%0d mreq_addr", i), mreq_addr, v.ea);
            chk($sformatf("vec%0d mreq_write", i), mreq_write, v.ew);
            chk($sformatf("vec%0d mreq_strobe", i), mreq_strobe, v.es);
            chk($sformatf("vec%0d mreq_data", i), mreq_data, v.edt);
         end
         chk($sformatf("vec%0d iresp_ok", i), iresp_data_ok, v.eiok);
         chk($sformatf("vec%0d dresp_ok", i), dresp_data_ok, v.edok);
         if (v.eiok) chk($sformatf("vec%0d iresp_data", i), iresp_data, v.eid);
         if (v.edok) chk($sformatf("vec%0d dresp_data", i), dresp_data, v.md);
         @(posedge clk); #1;
      end

      // starvation guard: grant order with both requesters held
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1, 64'h1000, 1, 64'h2000, 0, 0, 0, 0, 0);
      run_grants(6, g);
      chk_str("starve order", g, "DDDDID");

      // reset in the second DBUSY cycle, late completion afterwards
      @(posedge clk); #1;              // data granted here
      @(posedge clk); #1;              // second DBUSY cycle
      reset = 1'b1;
      @(negedge clk);
      chk("rstload busy", mreq_valid, 1);
      chk("rstload addr", mreq_addr, 64'h2000);
      chk("rstload dresp_ok pre", dresp_data_ok, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 64'h77);
      reset = 1'b0;
      @(negedge clk);
      chk("rstload mreq_valid", mreq_valid, 0);
      chk("rstload dresp_ok", dresp_data_ok, 0);
      chk("rstload iresp_ok", iresp_data_ok, 0);
      @(posedge clk); #1;
      // streak cleared by reset: four data grants again before the fetch
      drive(1, 64'h1000, 1, 64'h2000, 0, 0, 0, 0, 0);
      run_grants(5, g);
      chk_str("post-reset order", g, "DDDDI");

      // randomized traffic against the model
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 63) == 0);
         ireq_valid    = $urandom_range(0, 1);
         ireq_addr     = {$urandom, $urandom} & ~64'h3;
         dreq_valid    = $urandom_range(0, 1);
         dreq_addr     = {$urandom, $urandom};
         dreq_write    = $urandom_range(0, 1);
         dreq_strobe   = 8'($urandom);
         dreq_data     = {$urandom, $urandom};
         mresp_data_ok = ($urandom_range(0, 2) == 0);
         mresp_data    = {$urandom, $urandom};
         @(negedge clk);
         model_check();
         model_step();
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
